// File: rtl/mem_seq_pkg.sv
// mem_seq_pkg
// Shared definitions for the MEM-stage access sequencer: FSM state
// encoding, fault codes, and the decoder's mem_size / mem_rw encodings.
package mem_seq_pkg;

    // Sequencer states: IDLE (accepting), REQ (bus busy), DONE (one-cycle result)
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_MISALIGN = 2'b01;
    localparam logic [1:0] FC_TIMEOUT  = 2'b10;

    localparam logic MEM_SIZE_BYTE = 1'b0;
    localparam logic MEM_SIZE_WORD = 1'b1;
    localparam logic MEM_READ      = 1'b0;
    localparam logic MEM_WRITE     = 1'b1;

endpackage

// File: rtl/byte_lane_steer.sv
// byte_lane_steer
// Combinational byte-lane steering for a 32-bit data memory.
// Ports:
//   i_size, i_addr_lo, i_store_data : request side (new access)
//   o_be, o_wdata                   : byte enables / store data, byte replicated on all lanes
//   i_rd_size, i_rd_addr_lo, i_rdata: load side (latched access + returned word)
//   o_load_data                     : load result, byte loads zero-extended
module byte_lane_steer
    import mem_seq_pkg::*;
(
    input  logic        i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_store_data,
    input  logic        i_rd_size,
    input  logic [1:0]  i_rd_addr_lo,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data
);

    // Byte enables and store data for the request being launched
    always_comb begin
        o_be    = 4'b0000;
        o_wdata = 32'h0000_0000;
        if (i_size == MEM_SIZE_WORD) begin
            o_be    = 4'b1111;
            o_wdata = i_store_data;
        end else begin
            // Replicating the byte lets the memory pick any lane via be
            o_wdata = {4{i_store_data[7:0]}};
            case (i_addr_lo)
                2'd0:    o_be = 4'b0001;
                2'd1:    o_be = 4'b0010;
                2'd2:    o_be = 4'b0100;
                2'd3:    o_be = 4'b1000;
                default: o_be = 4'b0000;
            endcase
        end
    end

    // Load result selection: whole word, or one zero-extended byte lane
    always_comb begin
        o_load_data = 32'h0000_0000;
        if (i_rd_size == MEM_SIZE_WORD) begin
            o_load_data = i_rdata;
        end else begin
            case (i_rd_addr_lo)
                2'd0:    o_load_data = {24'h00_0000, i_rdata[7:0]};
                2'd1:    o_load_data = {24'h00_0000, i_rdata[15:8]};
                2'd2:    o_load_data = {24'h00_0000, i_rdata[23:16]};
                2'd3:    o_load_data = {24'h00_0000, i_rdata[31:24]};
                default: o_load_data = 32'h0000_0000;
            endcase
        end
    end

endmodule

// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer
// MEM-stage sequencer: turns decoded load/store controls into a req/ready
// transaction on a word-wide data memory, stalls the pipeline while busy,
// and reports load results or faults (misaligned word, bus timeout).
// Ports:
//   clk, reset                        : clock, async active-high reset
//   mem_enable, mem_rw, mem_size      : decoded memory op controls
//   addr, store_data, flush           : effective address, store value, flush of MEM instr
//   stall                             : combinational pipeline hold
//   load_data, load_valid             : load result and its one-cycle valid pulse
//   fault, fault_code                 : one-cycle abort pulse and its cause
//   dmem_req/we/addr/wdata/be         : registered memory request fields
//   dmem_rdata, dmem_ready            : memory read word and completion
module mem_access_sequencer
    import mem_seq_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_enable,
    input  logic                  mem_rw,
    input  logic                  mem_size,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           store_data,
    input  logic                  flush,
    output logic                  stall,
    output logic [31:0]           load_data,
    output logic                  load_valid,
    output logic                  fault,
    output logic [1:0]            fault_code,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [31:0]           dmem_wdata,
    output logic [3:0]            dmem_be,
    input  logic [31:0]           dmem_rdata,
    input  logic                  dmem_ready
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    seq_state_t             r_state;
    logic [TMO_W-1:0]       r_tmo_cnt;
    logic                   r_discard;
    logic                   r_rd_size;
    logic [1:0]             r_addr_lo;
    logic [31:0]            r_load_data;
    logic                   r_load_valid;
    logic                   r_fault;
    logic [1:0]             r_fault_code;
    logic                   r_dmem_req;
    logic                   r_dmem_we;
    logic [ADDR_WIDTH-1:0]  r_dmem_addr;
    logic [31:0]            r_dmem_wdata;
    logic [3:0]             r_dmem_be;

    logic [3:0]             w_be;
    logic [31:0]            w_wdata;
    logic [31:0]            w_load_data;
    logic                   w_misaligned;
    logic                   w_discard;

    byte_lane_steer u_steer (
        .i_size       (mem_size),
        .i_addr_lo    (addr[1:0]),
        .i_store_data (store_data),
        .i_rd_size    (r_rd_size),
        .i_rd_addr_lo (r_addr_lo),
        .i_rdata      (dmem_rdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_load_data  (w_load_data)
    );

    assign w_misaligned = (mem_size == MEM_SIZE_WORD) && (addr[1:0] != 2'b00);
    // A flush seen in any REQ cycle, including the completing one, silences DONE
    assign w_discard    = r_discard | flush;

    assign stall = ((r_state == IDLE) && mem_enable && !flush) || (r_state == REQ);

    // Sequencer FSM with all registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_tmo_cnt    <= '0;
            r_discard    <= 1'b0;
            r_rd_size    <= 1'b0;
            r_addr_lo    <= 2'b00;
            r_load_data  <= 32'h0000_0000;
            r_load_valid <= 1'b0;
            r_fault      <= 1'b0;
            r_fault_code <= FC_NONE;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= 32'h0000_0000;
            r_dmem_be    <= 4'b0000;
        end else begin
            r_load_valid <= 1'b0;
            r_fault      <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_fault_code <= FC_NONE;
                    r_discard    <= 1'b0;
                    r_tmo_cnt    <= '0;
                    if (mem_enable && !flush) begin
                        if (w_misaligned) begin
                            r_fault      <= 1'b1;
                            r_fault_code <= FC_MISALIGN;
                            r_state      <= DONE;
                        end else begin
                            r_dmem_req   <= 1'b1;
                            r_dmem_we    <= (mem_rw == MEM_WRITE);
                            r_dmem_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
                            r_dmem_wdata <= w_wdata;
                            r_dmem_be    <= w_be;
                            r_rd_size    <= mem_size;
                            r_addr_lo    <= addr[1:0];
                            r_state      <= REQ;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                REQ: begin
                    r_discard <= w_discard;
                    // Ready wins over a simultaneous timeout
                    if (dmem_ready) begin
                        r_dmem_req <= 1'b0;
                        r_state    <= DONE;
                        if (!w_discard && !r_dmem_we) begin
                            r_load_valid <= 1'b1;
                            r_load_data  <= w_load_data;
                        end
                    end else if (r_tmo_cnt == TMO_LAST) begin
                        r_dmem_req <= 1'b0;
                        r_state    <= DONE;
                        if (!w_discard) begin
                            r_fault      <= 1'b1;
                            r_fault_code <= FC_TIMEOUT;
                        end
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    end
                end
                DONE: begin
                    r_fault_code <= FC_NONE;
                    r_state      <= IDLE;
                end
                default: begin
                    r_dmem_req <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign load_data  = r_load_data;
    assign load_valid = r_load_valid;
    assign fault      = r_fault;
    assign fault_code = r_fault_code;
    assign dmem_req   = r_dmem_req;
    assign dmem_we    = r_dmem_we;
    assign dmem_addr  = r_dmem_addr;
    assign dmem_wdata = r_dmem_wdata;
    assign dmem_be    = r_dmem_be;

endmodule
